// File: rtl/hazard_ctrl_pkg.sv
// hazard_ctrl_pkg: shared state encodings and counter width for the pipeline hazard controller
package hazard_ctrl_pkg;
   typedef enum logic {RUN = 1'b0, MD_WAIT = 1'b1} hz_state_t;
   localparam int STALL_W = 16;
endpackage

// File: rtl/load_use_detect.sv
// load_use_detect: flags an ID source register that depends on a load still in EX
module load_use_detect (
   input  logic       mem_read,
   input  logic [4:0] ex_rt,
   input  logic [4:0] id_rs,
   input  logic [4:0] id_rt,
   input  logic       uses_rt,
   output logic       hit
);
   assign hit = mem_read && ex_rt != 5'd0 && (ex_rt == id_rs || (uses_rt && ex_rt == id_rt));
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/flush/interrupt control for a 5-stage pipeline with multi-cycle mul/div
module hazard_ctrl
   import hazard_ctrl_pkg::*;
#(
   parameter int MULDIV_CYCLES = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [4:0]         ID_rs,
   input  logic [4:0]         ID_rt,
   input  logic               ID_uses_rt,
   input  logic               ID_EX_MemRead,
   input  logic [4:0]         ID_EX_rt,
   input  logic               ID_jump,
   input  logic               EX_branch_taken,
   input  logic               ID_muldiv,
   input  logic               irq,
   output logic               PC_write,
   output logic               IF_ID_write,
   output logic               IF_ID_flush,
   output logic               ID_EX_flush,
   output logic               irq_ack,
   output logic [STALL_W-1:0] stall_count
);
   hz_state_t  state, state_next;
   logic [2:0] md_cnt, md_cnt_next;
   logic       irq_pend, load_use;

   load_use_detect u_lud (
      .mem_read(ID_EX_MemRead),
      .ex_rt   (ID_EX_rt),
      .id_rs   (ID_rs),
      .id_rt   (ID_rt),
      .uses_rt (ID_uses_rt),
      .hit     (load_use)
   );

   // Priority: reset, branch (also aborts a wrong-path mul/div), mul/div wait, jump, load-use, new mul/div, irq
   always_comb begin
      PC_write    = 1'b1;
      IF_ID_write = 1'b1;
      IF_ID_flush = 1'b0;
      ID_EX_flush = 1'b0;
      irq_ack     = 1'b0;
      state_next  = state;
      md_cnt_next = md_cnt;
      if (!reset) begin
         PC_write    = 1'b0;
         IF_ID_write = 1'b0;
      end else if (EX_branch_taken) begin
         IF_ID_flush = 1'b1;
         ID_EX_flush = 1'b1;
         state_next  = RUN;
         md_cnt_next = 3'd0;
      end else if (state == MD_WAIT) begin
         PC_write    = 1'b0;
         IF_ID_write = 1'b0;
         ID_EX_flush = 1'b1;
         md_cnt_next = md_cnt - 3'd1;
         state_next  = md_cnt <= 3'd1 ? RUN : MD_WAIT;
      end else if (ID_jump) begin
         IF_ID_flush = 1'b1;
      end else if (load_use || ID_muldiv) begin
         PC_write    = 1'b0;
         IF_ID_write = 1'b0;
         ID_EX_flush = 1'b1;
         state_next  = load_use ? RUN : MD_WAIT;
         md_cnt_next = load_use ? md_cnt : 3'(MULDIV_CYCLES - 1);
      end else if (irq_pend) begin
         irq_ack     = 1'b1;
         IF_ID_flush = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= RUN;
         md_cnt      <= 3'd0;
         irq_pend    <= 1'b0;
         stall_count <= '0;
      end else begin
         state       <= state_next;
         md_cnt      <= md_cnt_next;
         irq_pend    <= irq_ack ? 1'b0 : (irq_pend | irq);
         stall_count <= (!PC_write && stall_count != '1) ? stall_count + 1'b1 : stall_count;
      end
   end
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed scoreboard bench for hazard_ctrl (MULDIV_CYCLES = 4)
module tb_hazard_ctrl;
   logic        clk = 1'b0, reset = 1'b0;
   logic [4:0]  ID_rs = '0, ID_rt = '0, ID_EX_rt = '0;
   logic        ID_uses_rt = 0, ID_EX_MemRead = 0, ID_jump = 0, EX_branch_taken = 0, ID_muldiv = 0, irq = 0;
   logic        PC_write, IF_ID_write, IF_ID_flush, ID_EX_flush, irq_ack;
   logic [15:0] stall_count;

   typedef struct {
      logic [4:0]  ctl;
      logic [15:0] sc;
   } exp_t;
   exp_t sb[$];
   int   n_assert = 0, n_fail = 0, step_no = 0;
   logic [15:0] model_sc = 0;

   // {PC_write, IF_ID_write, IF_ID_flush, ID_EX_flush, irq_ack}
   localparam logic [4:0] NORM = 5'b11000, STALL = 5'b00010, JUMP = 5'b11100,
                          BR = 5'b11110, ACK = 5'b11101, RST = 5'b00000;

   hazard_ctrl #(.MULDIV_CYCLES(4)) dut (
      .clk(clk), .reset(reset), .ID_rs(ID_rs), .ID_rt(ID_rt), .ID_uses_rt(ID_uses_rt),
      .ID_EX_MemRead(ID_EX_MemRead), .ID_EX_rt(ID_EX_rt), .ID_jump(ID_jump),
      .EX_branch_taken(EX_branch_taken), .ID_muldiv(ID_muldiv), .irq(irq),
      .PC_write(PC_write), .IF_ID_write(IF_ID_write), .IF_ID_flush(IF_ID_flush),
      .ID_EX_flush(ID_EX_flush), .irq_ack(irq_ack), .stall_count(stall_count)
   );

   always #5 clk = ~clk;

   task automatic cmp(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s@step%0d: observed %0h expected %0h", tag, step_no, obs, exp);
      end
   endtask

   task automatic expect_push(input logic [4:0] ctl);
      exp_t e;
      e.ctl = ctl;
      e.sc  = model_sc;
      sb.push_back(e);
   endtask

   task automatic check();
      exp_t e;
      step_no++;
      if (sb.size() == 0) begin
         cmp("scoreboard_empty", 16'd1, 16'd0);
         return;
      end
      e = sb.pop_front();
      cmp("PC_write", 16'(PC_write), 16'(e.ctl[4]));
      cmp("IF_ID_write", 16'(IF_ID_write), 16'(e.ctl[3]));
      cmp("IF_ID_flush", 16'(IF_ID_flush), 16'(e.ctl[2]));
      cmp("ID_EX_flush", 16'(ID_EX_flush), 16'(e.ctl[1]));
      cmp("irq_ack", 16'(irq_ack), 16'(e.ctl[0]));
      cmp("stall_count", stall_count, e.sc);
      if (reset && !e.ctl[4]) model_sc++;
   endtask

   task automatic step(input logic [4:0] e, input logic [4:0] rs, input logic [4:0] rt,
                       input logic urt, input logic mr, input logic [4:0] ert,
                       input logic jmp, input logic br, input logic md, input logic iq);
      @(posedge clk);
      #1;
      ID_rs = rs; ID_rt = rt; ID_uses_rt = urt; ID_EX_MemRead = mr; ID_EX_rt = ert;
      ID_jump = jmp; EX_branch_taken = br; ID_muldiv = md; irq = iq;
      expect_push(e);
      @(negedge clk);
      check();
   endtask

   task automatic idle(input logic [4:0] e);
      step(e, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      #2;
      expect_push(RST);
      check();
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
      idle(NORM);
      // load-use on rs, then stall_count shows the single stall
      step(STALL, 5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0);
      idle(NORM);
      // r0 destination never stalls
      step(NORM, 5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      // rt match ignored unless rt is read
      step(NORM, 5'd3, 5'd5, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0);
      step(STALL, 5'd3, 5'd5, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0);
      // no load in EX -> no stall
      step(NORM, 5'd5, 5'd5, 1'b1, 1'b0, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0);
      // mul/div: exactly four stall cycles, then RUN
      step(STALL, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      repeat (3) idle(STALL);
      idle(NORM);
      idle(NORM);
      // jump and branch in RUN
      step(JUMP, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
      step(BR, 5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0);
      // branch in the 2nd MD_WAIT cycle aborts the mul/div
      step(STALL, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      idle(STALL);
      step(BR, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
      idle(NORM);
      idle(NORM);
      // irq together with load-use: deferred, then one ack pulse
      step(STALL, 5'd7, 5'd0, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, 1'b1);
      idle(ACK);
      idle(NORM);
      // irq during mul/div stall waits for the first RUN cycle
      step(STALL, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      step(STALL, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
      idle(STALL);
      idle(STALL);
      idle(ACK);
      idle(NORM);
      // jump outranks a pending irq
      step(STALL, 5'd9, 5'd0, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, 1'b1);
      step(JUMP, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
      idle(ACK);
      idle(NORM);
      // asynchronous reset in the middle of MD_WAIT
      step(STALL, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      idle(STALL);
      @(posedge clk);
      #2 reset = 1'b0;
      #1;
      model_sc = 0;
      expect_push(RST);
      check();
      @(posedge clk);
      @(negedge clk);
      expect_push(RST);
      check();
      reset = 1'b1;
      idle(NORM);
      idle(NORM);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter MULDIV_CYCLES, default 4 (range 2..8): ID-stage stall length, in cycles, for a mul/div issue.
REQ-002 SHALL have port clk, input, 1: single clock, rising edge.
REQ-003 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have ports ID_rs and ID_rt, input, 5 each: source registers of the instruction in ID.
REQ-005 SHALL have port ID_uses_rt, input, 1: the ID instruction reads rt.
REQ-006 SHALL have ports ID_EX_MemRead (input, 1) and ID_EX_rt (input, 5): the instruction in EX is a load, and its destination register.
REQ-007 SHALL have port ID_jump, input, 1: jump decoded in ID.
REQ-008 SHALL have port EX_branch_taken, input, 1: branch resolved taken in EX.
REQ-009 SHALL have port ID_muldiv, input, 1: the ID instruction is a multi-cycle mul/div.
REQ-010 SHALL have port irq, input, 1: level interrupt request.
REQ-011 SHALL have outputs PC_write, IF_ID_write, IF_ID_flush and ID_EX_flush, 1 bit each: the pipeline register controls.
REQ-012 SHALL have output irq_ack, 1: one-cycle interrupt-accept pulse.
REQ-013 SHALL have output stall_count, 16: saturating count of stall cycles.

Function
REQ-014 SHALL implement FSM states RUN and MD_WAIT, plus a 3-bit down-counter md_cnt.
REQ-015 SHALL drive control outputs combinationally from the current state and inputs; they are sampled by the pipeline registers on the same edge.
REQ-016 SHALL, in RUN, when EX_branch_taken=1: IF_ID_flush=1, ID_EX_flush=1, PC_write=1, IF_ID_write=1 (highest priority).
REQ-017 SHALL, in RUN, when ID_jump=1 (no branch): IF_ID_flush=1, ID_EX_flush=0, PC_write=1.
REQ-018 SHALL detect load-use as ID_EX_MemRead & (ID_EX_rt!=0) & (ID_EX_rt==ID_rs | (ID_uses_rt & ID_EX_rt==ID_rt)).
REQ-019 SHALL, on load-use with no branch or jump: PC_write=0, IF_ID_write=0, IF_ID_flush=0, ID_EX_flush=1 (bubble) for exactly that cycle.
REQ-020 SHALL, on ID_muldiv=1 in RUN with no higher-priority event: load md_cnt=MULDIV_CYCLES-1, go to MD_WAIT, and stall as in REQ-019 in that cycle.
REQ-021 SHALL, in MD_WAIT: stall as in REQ-019 and decrement md_cnt; at md_cnt==1, return to RUN next edge, so total stall = MULDIV_CYCLES cycles.
REQ-022 SHALL, on EX_branch_taken in MD_WAIT: abort to RUN next edge, clear md_cnt, and apply the REQ-016 outputs (the mul/div is wrong-path).
REQ-023 SHALL latch irq into irq_pend; accept only in RUN with no branch, jump, load-use or mul/div event.
REQ-024 SHALL, on accept: irq_ack=1 for one cycle, IF_ID_flush=1, ID_EX_flush=0, and clear irq_pend next edge.
REQ-025 SHALL, when irq arrives during a stall: hold it pending and accept in the first eligible RUN cycle.
REQ-026 SHALL increment stall_count in every cycle with PC_write=0, saturating at 16'hFFFF.
REQ-027 SHALL default outputs to PC_write=1, IF_ID_write=1, both flushes 0, irq_ack=0.

Reset
REQ-028 SHALL, while reset=0: state=RUN, md_cnt=0, irq_pend=0, stall_count=0.
REQ-029 SHALL force outputs to PC_write=0, IF_ID_write=0, flushes 0, irq_ack=0 during reset, including when reset is asserted mid-MD_WAIT.
REQ-030 SHALL resume normal operation at the first rising clk edge after reset deasserts.

Structure
REQ-031 SHALL place state encodings (RUN=1'b0, MD_WAIT=1'b1) and the stall_count width in the shared CPU package.
REQ-032 SHALL contain one sub-module, load_use_detect (combinational REQ-018 comparator); all sequential logic stays in hazard_ctrl.

Verification
REQ-033 SHALL cover: ID_EX_MemRead=1, ID_EX_rt=5, ID_rs=5 -> one cycle PC_write=0, ID_EX_flush=1, stall_count=1.
REQ-034 SHALL cover: the same stimulus with ID_EX_rt=0 -> no stall.
REQ-035 SHALL cover: ID_muldiv=1, MULDIV_CYCLES=4 -> PC_write=0 for exactly 4 cycles, then RUN, stall_count=4.
REQ-036 SHALL cover: EX_branch_taken=1 in the 2nd MD_WAIT cycle -> IF_ID_flush=1, ID_EX_flush=1, RUN on the next cycle.
REQ-037 SHALL cover: irq=1 together with load-use -> irq_ack deferred one cycle, then a single pulse with IF_ID_flush=1.
REQ-038 SHALL cover: reset=0 mid-MD_WAIT -> PC_write=0 immediately; state=RUN and stall_count=0 after release.
